// File: rtl/scr_stack_ctrl.sv
// Stack pointer / depth tracker and scratch-memory address, data and write-enable steering.
// Define STACK_GUARD_EN to suppress pushes when full and pops when empty, with sticky OVF/UNF flags.
module scr_stack_ctrl #(
  parameter logic [7:0] SP_RESET = 8'h00
) (
  input  logic       SP_CLK,
  input  logic       SP_RST_N,
  input  logic       SP_LD,
  input  logic       SP_INCR,
  input  logic       SP_DECR,
  input  logic [7:0] SP_DIN,
  input  logic [1:0] ADDR_SEL,
  input  logic       DATA_SEL,
  input  logic       WE_IN,
  input  logic [7:0] REG_DX,
  input  logic [7:0] REG_DY,
  input  logic [7:0] IMM,
  input  logic [9:0] PC,
  output logic [7:0] SCR_ADDR,
  output logic [9:0] SCR_DIN,
  output logic       SCR_WE,
  output logic [7:0] SP_OUT,
  output logic [8:0] SP_DEPTH,
  output logic       SP_EMPTY,
  output logic       SP_FULL,
  output logic       SP_OVF,
  output logic       SP_UNF
);

  localparam logic [8:0] DEPTH_MAX = 9'd256;

  logic [7:0] sp_q, sp_d;
  logic [8:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic       push_req, pop_req;
  logic       push_blk, pop_blk;
  logic       empty, full;
  logic [7:0] sp_m1;

  // Simultaneous INCR and DECR cancel out: neither counts as push nor pop.
  assign push_req = SP_DECR & ~SP_INCR;
  assign pop_req  = SP_INCR & ~SP_DECR;
  assign empty    = (depth_q == 9'd0);
  assign full     = (depth_q == DEPTH_MAX);
  assign sp_m1    = sp_q - 8'd1;

`ifdef STACK_GUARD_EN
  assign push_blk = push_req & full  & ~SP_LD;
  assign pop_blk  = pop_req  & empty & ~SP_LD;
`else
  assign push_blk = 1'b0;
  assign pop_blk  = 1'b0;
`endif

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (SP_LD) begin
      sp_d    = SP_DIN;
      depth_d = 9'd0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push_req) begin
      if (push_blk) begin
        ovf_d = 1'b1;
      end else begin
        sp_d    = sp_m1;
        depth_d = full ? depth_q : depth_q + 9'd1;
      end
    end else if (pop_req) begin
      if (pop_blk) begin
        unf_d = 1'b1;
      end else begin
        sp_d    = sp_q + 8'd1;
        depth_d = empty ? depth_q : depth_q - 9'd1;
      end
    end
  end

  always_ff @(posedge SP_CLK or negedge SP_RST_N) begin
    if (!SP_RST_N) begin
      sp_q    <= SP_RESET;
      depth_q <= 9'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // SP-1 is taken from the current SP so a push writes where SP lands after the edge.
  always_comb begin
    SCR_ADDR = REG_DY;
    case (ADDR_SEL)
      2'd0: SCR_ADDR = REG_DY;
      2'd1: SCR_ADDR = IMM;
      2'd2: SCR_ADDR = sp_q;
      2'd3: SCR_ADDR = sp_m1;
      default: SCR_ADDR = REG_DY;
    endcase
  end

  assign SCR_DIN  = DATA_SEL ? PC : {2'b00, REG_DX};
  assign SCR_WE   = WE_IN & ~push_blk;
  assign SP_OUT   = sp_q;
  assign SP_DEPTH = depth_q;
  assign SP_EMPTY = empty;
  assign SP_FULL  = full;
  assign SP_OVF   = ovf_q;
  assign SP_UNF   = unf_q;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed table-driven bench for scr_stack_ctrl plus hand-written wrap, reset and full-stack sequences.
module tb_scr_stack_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sp_ld, sp_incr, sp_decr;
  logic [7:0] sp_din;
  logic [1:0] addr_sel;
  logic       data_sel;
  logic       we_in;
  logic [7:0] reg_dx, reg_dy, imm;
  logic [9:0] pc;
  logic [7:0] scr_addr;
  logic [9:0] scr_din;
  logic       scr_we;
  logic [7:0] sp_out;
  logic [8:0] sp_depth;
  logic       sp_empty, sp_full, sp_ovf, sp_unf;

  int n_cmp = 0;
  int n_err = 0;

  scr_stack_ctrl dut (
    .SP_CLK   (clk),
    .SP_RST_N (rst_n),
    .SP_LD    (sp_ld),
    .SP_INCR  (sp_incr),
    .SP_DECR  (sp_decr),
    .SP_DIN   (sp_din),
    .ADDR_SEL (addr_sel),
    .DATA_SEL (data_sel),
    .WE_IN    (we_in),
    .REG_DX   (reg_dx),
    .REG_DY   (reg_dy),
    .IMM      (imm),
    .PC       (pc),
    .SCR_ADDR (scr_addr),
    .SCR_DIN  (scr_din),
    .SCR_WE   (scr_we),
    .SP_OUT   (sp_out),
    .SP_DEPTH (sp_depth),
    .SP_EMPTY (sp_empty),
    .SP_FULL  (sp_full),
    .SP_OVF   (sp_ovf),
    .SP_UNF   (sp_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld, incr, decr;
    logic [7:0] din;
    logic [1:0] asel;
    logic       dsel;
    logic       we;
    logic [7:0] dx;
    logic [9:0] pc;
    logic [7:0] e_addr;
    logic [9:0] e_din;
    logic       e_we;
    logic [7:0] e_sp;
    logic [8:0] e_depth;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic incr, input logic decr, input logic [7:0] din,
                       input logic [1:0] asel, input logic dsel, input logic we);
    sp_ld = ld; sp_incr = incr; sp_decr = decr; sp_din = din;
    addr_sel = asel; data_sel = dsel; we_in = we;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] sp, input logic [8:0] depth,
                           input logic ovf, input logic unf);
    chk({tag, ".sp"}, sp_out, sp);
    chk({tag, ".depth"}, sp_depth, depth);
    chk({tag, ".empty"}, sp_empty, depth == 9'd0);
    chk({tag, ".full"}, sp_full, depth == 9'd256);
    chk({tag, ".ovf"}, sp_ovf, ovf);
    chk({tag, ".unf"}, sp_unf, unf);
  endtask

  initial begin
    //          ld   incr decr din    asel  dsel we   dx     pc      addr   din     we   sp     depth
    vecs[0]  = '{1'b0,1'b0,1'b1,8'h00,2'd3,1'b0,1'b1,8'h5A,10'h000,8'hFF,10'h05A,1'b1,8'hFF,9'd1};
    vecs[1]  = '{1'b0,1'b1,1'b0,8'h00,2'd2,1'b0,1'b0,8'h5A,10'h000,8'hFF,10'h05A,1'b0,8'h00,9'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,8'h00,2'd3,1'b1,1'b1,8'h5A,10'h2C3,8'hFF,10'h2C3,1'b1,8'hFF,9'd1};
    vecs[3]  = '{1'b0,1'b0,1'b1,8'h00,2'd3,1'b0,1'b1,8'h11,10'h2C3,8'hFE,10'h011,1'b1,8'hFE,9'd2};
    vecs[4]  = '{1'b0,1'b1,1'b1,8'h00,2'd0,1'b0,1'b0,8'h11,10'h2C3,8'h12,10'h011,1'b0,8'hFE,9'd2};
    vecs[5]  = '{1'b0,1'b1,1'b1,8'h00,2'd1,1'b0,1'b0,8'h11,10'h2C3,8'h34,10'h011,1'b0,8'hFE,9'd2};
    vecs[6]  = '{1'b0,1'b1,1'b1,8'h00,2'd2,1'b1,1'b0,8'h11,10'h2C3,8'hFE,10'h2C3,1'b0,8'hFE,9'd2};
    vecs[7]  = '{1'b1,1'b0,1'b1,8'h80,2'd3,1'b0,1'b0,8'h11,10'h2C3,8'hFD,10'h011,1'b0,8'h80,9'd0};
    vecs[8]  = '{1'b0,1'b0,1'b1,8'h00,2'd3,1'b0,1'b1,8'h11,10'h2C3,8'h7F,10'h011,1'b1,8'h7F,9'd1};
    vecs[9]  = '{1'b0,1'b1,1'b0,8'h00,2'd2,1'b0,1'b0,8'h11,10'h2C3,8'h7F,10'h011,1'b0,8'h80,9'd0};
    vecs[10] = '{1'b1,1'b0,1'b0,8'hFF,2'd0,1'b0,1'b0,8'h11,10'h2C3,8'h12,10'h011,1'b0,8'hFF,9'd0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
    reg_dx = 8'h00; reg_dy = 8'h12; imm = 8'h34; pc = 10'h000;
    #2;
    chk_state("reset", 8'h00, 9'd0, 1'b0, 1'b0);
    chk("reset.addr", scr_addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("idle", 8'h00, 9'd0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].ld, vecs[i].incr, vecs[i].decr, vecs[i].din, vecs[i].asel, vecs[i].dsel, vecs[i].we);
      reg_dx = vecs[i].dx; pc = vecs[i].pc;
      #1;
      chk($sformatf("v%0d.addr", i), scr_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.din", i), scr_din, vecs[i].e_din);
      chk($sformatf("v%0d.we", i), scr_we, vecs[i].e_we);
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), vecs[i].e_sp, vecs[i].e_depth, 1'b0, 1'b0);
      $display("vec %0d: addr=%0h din=%0h we=%0b sp=%0h depth=%0d", i, scr_addr, scr_din, scr_we, sp_out, sp_depth);
    end

    // Pop at SP=FF with zero depth
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
    #1 chk("popempty.addr", scr_addr, 8'hFF);
    @(posedge clk); #1;
`ifdef STACK_GUARD_EN
    chk_state("popempty", 8'hFF, 9'd0, 1'b0, 1'b1);
`else
    chk_state("popempty", 8'h00, 9'd0, 1'b0, 1'b0);
`endif
    $display("pop-empty: sp=%0h depth=%0d unf=%0b", sp_out, sp_depth, sp_unf);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h10, 2'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("ldclr", 8'h10, 9'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_state("prerst", 8'h0F, 9'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("asyncrst", 8'h00, 9'd0, 1'b0, 1'b0);
    $display("async reset: sp=%0h depth=%0d", sp_out, sp_depth);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole stack
    drive(1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b1);
    pc = 10'h3FF;
    for (int i = 0; i < 256; i++) @(posedge clk);
    #1;
    chk_state("fill", 8'h00, 9'd256, 1'b0, 1'b0);
    $display("fill: sp=%0h depth=%0d full=%0b", sp_out, sp_depth, sp_full);
    @(negedge clk);
`ifdef STACK_GUARD_EN
    chk("push257.we", scr_we, 1'b0);
`else
    chk("push257.we", scr_we, 1'b1);
`endif
    @(posedge clk); #1;
`ifdef STACK_GUARD_EN
    chk_state("push257", 8'h00, 9'd256, 1'b1, 1'b0);
`else
    chk_state("push257", 8'hFF, 9'd256, 1'b0, 1'b0);
`endif
    $display("push257: sp=%0h depth=%0d ovf=%0b", sp_out, sp_depth, sp_ovf);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("ldfinal", 8'h00, 9'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
